// File: rtl/fare_arbiter.sv
// fare_arbiter -- round-robin arbiter granting four fare gates access to one
// shared fare processor. One transaction at a time: pick a gate, pulse
// bal_start, wait for bal_done, then return a one-cycle ack with the result.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   req[3:0]   in   per-gate request, held until that gate's ack
//   bal_done   in   processor finished (one-cycle pulse)
//   bal_ok     in   processor result, valid with bal_done
//   bal_start  out  one-cycle launch pulse to the processor
//   bal_gate   out  index of the gate being served
//   ack[3:0]   out  one-hot, one-cycle acknowledge to the served gate
//   ack_ok     out  result for the acknowledged gate, 0 when ack == 0
//   busy       out  high whenever the FSM is not idle
//   timeout    out  one-cycle pulse when a transaction is aborted by timeout
//
// Build option
//   FARE_ARB_TIMEOUT_EN  when defined, a wait of 200 cycles without bal_done
//                        aborts the transaction with ack_ok = 0, timeout = 1.
//                        When undefined, the FSM waits indefinitely and
//                        timeout is tied low.

module fare_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       bal_done,
  input  logic       bal_ok,
  output logic       bal_start,
  output logic [1:0] bal_gate,
  output logic [3:0] ack,
  output logic       ack_ok,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t     state_q;
  logic [1:0] ptr_q;
  logic [1:0] gate_q;
  logic       start_q;
  logic [3:0] ack_q;
  logic       res_q;
  logic       busy_q;
  logic [1:0] grant_d;

`ifdef FARE_ARB_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'd199;
  logic [7:0] cnt_q;
  logic       tmo_q;
`endif

  // First requesting gate in scan order ptr, ptr+1, ... (2-bit wrap).
  // Scanning from the far end lets the nearest hit overwrite later ones.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] g);
    onehot = 4'b0001 << g;
  endfunction

  always_comb begin
    grant_d = rr_pick(req, ptr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      gate_q  <= 2'd0;
      start_q <= 1'b0;
      ack_q   <= 4'd0;
      res_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FARE_ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; the captured result lives only in ACK.
      start_q <= 1'b0;
      ack_q   <= 4'd0;
      res_q   <= 1'b0;
`ifdef FARE_ARB_TIMEOUT_EN
      tmo_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            gate_q  <= grant_d;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end else begin
            busy_q  <= 1'b0;
          end
        end

        // bal_done is deliberately ignored here; only WAIT listens to it.
        S_START: begin
          state_q <= S_WAIT;
`ifdef FARE_ARB_TIMEOUT_EN
          cnt_q   <= 8'd0;
`endif
        end

        S_WAIT: begin
          if (bal_done) begin
            res_q   <= bal_ok;
            ack_q   <= onehot(gate_q);
            state_q <= S_ACK;
`ifdef FARE_ARB_TIMEOUT_EN
          end else if (cnt_q == WAIT_LAST) begin
            // 200th wait cycle ended with no answer: abort with failure.
            res_q   <= 1'b0;
            ack_q   <= onehot(gate_q);
            tmo_q   <= 1'b1;
            state_q <= S_ACK;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
`endif
          end
        end

        // Served gate drops to lowest priority for the next arbitration.
        S_ACK: begin
          ptr_q   <= gate_q + 2'd1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bal_start = start_q;
  assign bal_gate  = gate_q;
  assign ack       = ack_q;
  assign ack_ok    = res_q;
  assign busy      = busy_q;

`ifdef FARE_ARB_TIMEOUT_EN
  assign timeout   = tmo_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_fare_arbiter.sv
module tb_fare_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       bal_done;
  logic       bal_ok;
  logic       bal_start;
  logic [1:0] bal_gate;
  logic [3:0] ack;
  logic       ack_ok;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  fare_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .bal_done  (bal_done),
    .bal_ok    (bal_ok),
    .bal_start (bal_start),
    .bal_gate  (bal_gate),
    .ack       (ack),
    .ack_ok    (ack_ok),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'd0; bal_done = 1'b0; bal_ok = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Step until bal_start is seen, at most 10 cycles; n = 99 if never seen.
  task automatic to_start(output int n);
    n = 99;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bal_start === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // One full transaction: w wait cycles before bal_done; leaves time in the ACK cycle.
  task automatic do_txn(input logic ok, input int w, output logic [1:0] g,
                        output logic [3:0] a, output logic aok, output int n);
    to_start(n);
    g = bal_gate;
    repeat (w) step();
    bal_done = 1'b1; bal_ok = ok;
    step();
    bal_done = 1'b0; bal_ok = 1'b0;
    a = ack; aok = ack_ok;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bal_start, ack, ack_ok, busy, timeout, bal_gate} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got start=%b ack=%b ok=%b busy=%b tmo=%b gate=%0d want all 0",
               bal_start, ack, ack_ok, busy, timeout, bal_gate);
    end
  endtask

  task automatic test_basic();
    logic [1:0] g; logic [3:0] a; logic aok; int n;
    do_reset();
    req = 4'b0001;
    do_txn(1'b1, 2, g, a, aok, n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL basic_start_latency got %0d want 1", n); end
    checks++;
    if (g !== 2'd0) begin errors++; $display("FAIL basic_gate got %0d want 0", g); end
    checks++;
    if (a !== 4'b0001) begin errors++; $display("FAIL basic_ack got %b want 0001", a); end
    checks++;
    if (aok !== 1'b1) begin errors++; $display("FAIL basic_ack_ok got %b want 1", aok); end
    checks++;
    if (bal_start !== 1'b0) begin errors++; $display("FAIL basic_start_in_ack got %b want 0", bal_start); end
    // ptr is now 1: gates 0,1,3 requesting -> gate 1 wins.
    req = 4'b1011;
    do_txn(1'b1, 1, g, a, aok, n);
    checks++;
    if (g !== 2'd1) begin errors++; $display("FAIL basic_ptr_after got %0d want 1", g); end
    req = 4'd0;
    step();
  endtask

  task automatic test_rotation();
    logic [1:0] g; logic [3:0] a; logic aok; int n;
    logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      do_txn(1'b1, 1, g, a, aok, n);
      checks++;
      if (g !== exp_g[t]) begin errors++; $display("FAIL rot_gate[%0d] got %0d want %0d", t, g, exp_g[t]); end
      checks++;
      if (a !== (4'b0001 << exp_g[t])) begin
        errors++; $display("FAIL rot_ack[%0d] got %b want %b", t, a, 4'b0001 << exp_g[t]);
      end
      if (t > 0) begin
        checks++;
        if (n !== 2) begin errors++; $display("FAIL rot_back_to_back[%0d] got %0d want 2", t, n); end
      end
    end
    req = 4'd0;
    step();
  endtask

  task automatic test_ptr3();
    logic [1:0] g; logic [3:0] a; logic aok; int n;
    do_reset();
    req = 4'b0100;
    do_txn(1'b1, 1, g, a, aok, n);
    req = 4'b0110;                 // ptr becomes 3
    do_txn(1'b1, 1, g, a, aok, n);
    checks++;
    if (g !== 2'd1) begin errors++; $display("FAIL ptr3_first got %0d want 1", g); end
    req = 4'b0100;
    do_txn(1'b1, 1, g, a, aok, n);
    checks++;
    if (g !== 2'd2) begin errors++; $display("FAIL ptr3_second got %0d want 2", g); end
    checks++;
    if (a !== 4'b0100) begin errors++; $display("FAIL ptr3_second_ack got %b want 0100", a); end
    req = 4'd0;
    step();
  endtask

  task automatic test_fail_and_ignore();
    do_reset();
    req = 4'b0001;
    step();
    checks++;
    if (bal_start !== 1'b1) begin errors++; $display("FAIL fail_start got %b want 1", bal_start); end
    bal_done = 1'b1; bal_ok = 1'b1;   // must be ignored in START
    step();
    bal_done = 1'b0; bal_ok = 1'b0;
    repeat (3) step();
    checks++;
    if ({bal_start, ack, busy} !== 6'b000001) begin
      errors++; $display("FAIL start_done_ignored got start=%b ack=%b busy=%b want 0 0000 1", bal_start, ack, busy);
    end
    bal_done = 1'b1; bal_ok = 1'b0;
    step();
    bal_done = 1'b0;
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("FAIL fail_ack got %b want 0001", ack); end
    checks++;
    if (ack_ok !== 1'b0) begin errors++; $display("FAIL fail_ack_ok got %b want 0", ack_ok); end
    req = 4'd0;
    step();
    checks++;
    if ({ack, ack_ok, busy} !== 6'd0) begin
      errors++; $display("FAIL after_ack got ack=%b ok=%b busy=%b want 0", ack, ack_ok, busy);
    end
    bal_done = 1'b1; bal_ok = 1'b1;   // stray pulse in IDLE
    step();
    bal_done = 1'b0; bal_ok = 1'b0;
    step();
    checks++;
    if ({ack, busy, bal_start} !== 6'd0) begin
      errors++; $display("FAIL idle_done_ignored got ack=%b busy=%b start=%b want 0", ack, busy, bal_start);
    end
  endtask

  task automatic test_req_drop();
    logic [1:0] g; logic [3:0] a; logic aok; int n;
    do_reset();
    req = 4'b0011;
    to_start(n);
    checks++;
    if (bal_gate !== 2'd0) begin errors++; $display("FAIL drop_gate got %0d want 0", bal_gate); end
    step();
    req = 4'b0010;                 // gate 0 withdraws while waiting
    step();
    bal_done = 1'b1; bal_ok = 1'b1;
    step();
    bal_done = 1'b0; bal_ok = 1'b0;
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("FAIL drop_still_acked got %b want 0001", ack); end
    do_txn(1'b1, 1, g, a, aok, n);
    checks++;
    if (a !== 4'b0010) begin errors++; $display("FAIL pending_served got %b want 0010", a); end
    req = 4'd0;
    step();
  endtask

  task automatic test_mid_reset();
    logic [1:0] g; logic [3:0] a; logic aok; int n;
    do_reset();
    req = 4'b0010;
    do_txn(1'b1, 1, g, a, aok, n);  // ptr becomes 2
    req = 4'd0;
    step();
    req = 4'b0100;
    to_start(n);
    step();                        // in WAIT
    rst = 1'b1;
    step();
    rst = 1'b0; req = 4'd0;
    checks++;
    if ({busy, ack, bal_start} !== 6'd0) begin
      errors++; $display("FAIL midrst_clear got busy=%b ack=%b start=%b want 0", busy, ack, bal_start);
    end
    bal_done = 1'b1; bal_ok = 1'b1;
    step();
    bal_done = 1'b0; bal_ok = 1'b0;
    step();
    checks++;
    if ({busy, ack} !== 5'd0) begin
      errors++; $display("FAIL midrst_stray_done got busy=%b ack=%b want 0", busy, ack);
    end
    req = 4'b1111;
    do_txn(1'b1, 1, g, a, aok, n);
    checks++;
    if (g !== 2'd0) begin errors++; $display("FAIL midrst_ptr got %0d want 0", g); end
    req = 4'd0;
    step();
  endtask

`ifdef FARE_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n; int cnt;
    do_reset();
    req = 4'b0001;
    to_start(n);
    cnt = 0;
    while (ack === 4'd0 && cnt < 300) begin step(); cnt++; end
    checks++;
    if (cnt !== 201) begin errors++; $display("FAIL tmo_latency got %0d want 201", cnt); end
    checks++;
    if ({ack, ack_ok, timeout} !== 6'b000101) begin
      errors++; $display("FAIL tmo_ack got ack=%b ok=%b tmo=%b want 0001 0 1", ack, ack_ok, timeout);
    end
    req = 4'd0;
    step();
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_pulse got %b want 0", timeout); end
    req = 4'b0001;
    to_start(n);
    repeat (200) step();
    bal_done = 1'b1; bal_ok = 1'b1;
    step();
    bal_done = 1'b0; bal_ok = 1'b0;
    checks++;
    if ({ack, ack_ok, timeout} !== 6'b000110) begin
      errors++; $display("FAIL tmo_precedence got ack=%b ok=%b tmo=%b want 0001 1 0", ack, ack_ok, timeout);
    end
    req = 4'd0;
    step();
  endtask
`else
  task automatic test_timeout();
    int n; int seen;
    do_reset();
    req = 4'b0001;
    to_start(n);
    seen = 0;
    repeat (1000) begin
      step();
      if (ack !== 4'd0 || timeout !== 1'b0) seen++;
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL notmo_busy got %b want 1", busy); end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL notmo_no_ack got %0d want 0", seen); end
    do_reset();
  endtask
`endif

  initial begin
    rst = 1'b1; req = 4'd0; bal_done = 1'b0; bal_ok = 1'b0;
    test_reset();
    test_basic();
    test_rotation();
    test_ptr3();
    test_fail_and_ignore();
    test_req_drop();
    test_mid_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fare_arbiter.md
FARE_ARBITER -- requirements
Module: fare_arbiter

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 req  in  4  req[i] = gate i requests a fare deduction; gate holds it high until ack[i].
REQ-004 bal_done  in  1  one-cycle pulse from shared fare processor: transaction finished.
REQ-005 bal_ok  in  1  processor result (1 = card active and funds deducted); valid only with bal_done.
REQ-006 bal_start  out  1  one-cycle pulse launching the fare processor.
REQ-007 bal_gate  out  2  index of gate being served; held stable from bal_start until ack.
REQ-008 ack  out  4  one-hot, one-cycle pulse back to served gate.
REQ-009 ack_ok  out  1  result for the gate; valid only while ack is nonzero, else 0.
REQ-010 busy  out  1  high whenever state != IDLE.
REQ-011 timeout  out  1  one-cycle pulse when a transaction is aborted by timeout; constant 0 when the timeout feature is compiled out.

Function
REQ-012 FSM states SHALL be IDLE, START, WAIT, ACK; 2-bit round-robin pointer ptr.
REQ-013 IDLE: if req != 0, select the first set req bit scanning ptr, ptr+1, ... wrapping 3->0; register it into bal_gate; go START. If req == 0, stay IDLE.
REQ-014 START: bal_start = 1 for exactly this cycle; go WAIT.
REQ-015 WAIT: on bal_done = 1, capture bal_ok, go ACK; otherwise stay.
REQ-016 ACK: ack[bal_gate] = 1, ack_ok = captured result, ptr <= bal_gate + 1 (mod 4, 3 wraps to 0); go IDLE.
REQ-017 bal_done sampled in any state other than WAIT SHALL be ignored, including the START cycle.
REQ-018 Latency: bal_start asserts the cycle after req is first sampled in IDLE; ack asserts the cycle after bal_done; minimum 4 cycles per transaction.
REQ-019 A gate whose req drops before ack SHALL still receive its ack; no new grant until ACK completes.
REQ-020 A just-served gate SHALL have lowest priority in the next arbitration; four continuously requesting gates are served in strict rotation.
REQ-021 Simultaneous requests: only one grant per transaction; losing requests remain pending without loss.
REQ-022 At most one bit of ack is high in any cycle; bal_start and ack never assert in the same cycle.

Reset
REQ-023 While rst = 1 at a clock edge: state <= IDLE, ptr <= 0, captured result <= 0, bal_gate <= 0.
REQ-024 bal_start, ack, ack_ok, busy, timeout SHALL be 0 in the cycle after reset is sampled.
REQ-025 Reset mid-transaction SHALL abort without issuing ack; a later stray bal_done SHALL be ignored.

Configuration
REQ-026 Macro FARE_ARB_TIMEOUT_EN defined: 8-bit counter clears on WAIT entry, increments each WAIT cycle; if 200 WAIT cycles elapse without bal_done, go ACK with ack_ok = 0 and timeout = 1 in the ACK cycle; bal_done in the same cycle as expiry takes precedence (normal result, timeout = 0).
REQ-027 Macro not defined: no counter; WAIT holds indefinitely until bal_done; timeout tied 0.

Verification
REQ-028 Reset, then req = 4'b0001, bal_done+bal_ok=1 two cycles after bal_start -> bal_gate = 0, ack = 4'b0001, ack_ok = 1, ptr = 1.
REQ-029 req = 4'b1111 held, bal_done each time with bal_ok = 1 -> service order gates 0,1,2,3,0; one ack per transaction.
REQ-030 req = 4'b0110 with ptr = 3 -> gate 1 served first, then gate 2.
REQ-031 bal_done with bal_ok = 0 (inactive card / low funds) -> ack_ok = 0, ack[gate] = 1; pulse bal_done during START -> ignored, FSM remains in WAIT.
REQ-032 rst asserted during WAIT then bal_done -> no ack, busy = 0, ptr = 0.
REQ-033 With FARE_ARB_TIMEOUT_EN, no bal_done -> ack with ack_ok = 0 and timeout = 1 exactly 200 WAIT cycles after entry; without macro -> still busy after 1000 cycles.
